// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch, memory-wait and fetch-bubble
// stall/flush decode, wrong-path fetch discard flag and performance counters.
module hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs1_addr,
    input  logic [4:0]           id_rs2_addr,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_MemRead,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_branch_taken,
    input  logic                 if_busy,
    input  logic                 mem_busy,
    output logic [1:0]           pc_fs,
    output logic [1:0]           ifid_fs,
    output logic [1:0]           idex_fs,
    output logic [1:0]           exmem_fs,
    output logic [1:0]           memwb_fs,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic                 discard_pending
);

    localparam logic [1:0] FS_RUN   = 2'b00;
    localparam logic [1:0] FS_STALL = 2'b01;
    localparam logic [1:0] FS_FLUSH = 2'b10;

    logic                 r_discard;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_lu;
    logic w_discard;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_discard_nxt;

    // Load-use match and the cycle where a wrong-path fetch lands
    always_comb begin
        w_lu = ex_MemRead && (ex_rd_addr != 5'd0) &&
               ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
        w_discard = r_discard && !if_busy;
    end

    // Priority decode: mem wait > branch > load-use > fetch bubble > run
    always_comb begin
        pc_fs       = FS_RUN;
        ifid_fs     = FS_RUN;
        idex_fs     = FS_RUN;
        exmem_fs    = FS_RUN;
        memwb_fs    = FS_RUN;
        w_flush_inc = 1'b0;
        if (reset) begin
            w_flush_inc = 1'b0;
        end else if (mem_busy) begin
            pc_fs    = FS_STALL;
            ifid_fs  = FS_STALL;
            idex_fs  = FS_STALL;
            exmem_fs = FS_STALL;
            memwb_fs = FS_FLUSH;
        end else if (ex_branch_taken) begin
            ifid_fs     = FS_FLUSH;
            idex_fs     = FS_FLUSH;
            w_flush_inc = 1'b1;
        end else if (w_lu) begin
            pc_fs   = FS_STALL;
            ifid_fs = FS_STALL;
            idex_fs = FS_FLUSH;
        end else if (if_busy || w_discard) begin
            pc_fs       = FS_STALL;
            ifid_fs     = FS_FLUSH;
            w_flush_inc = w_discard;
        end
        w_stall_inc = (pc_fs == FS_STALL);
    end

    // Discard flag: set by a redirect during a fetch, cleared when it lands
    always_comb begin
        w_discard_nxt = r_discard;
        if (mem_busy) begin
            w_discard_nxt = r_discard;
        end else if (ex_branch_taken && if_busy) begin
            w_discard_nxt = 1'b1;
        end else if (!if_busy) begin
            w_discard_nxt = 1'b0;
        end
    end

    // State: discard flag and wrapping performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_discard   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_discard <= w_discard_nxt;
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_flush_inc) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign discard_pending = r_discard;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of the performance counters.
REQ-002 Port: clk, input, 1, pipeline clock.
REQ-003 Port: reset, input, 1, asynchronous active-high reset.
REQ-004 Port: id_rs1_addr, id_rs2_addr, input, 5 each, source register indices of the instruction in ID.
REQ-005 Port: id_uses_rs1, id_uses_rs2, input, 1 each, ID instruction reads rs1 / rs2.
REQ-006 Port: ex_MemRead, input, 1, instruction in EX is a load.
REQ-007 Port: ex_rd_addr, input, 5, destination index of the instruction in EX.
REQ-008 Port: ex_branch_taken, input, 1, branch or jump in EX redirects the PC this cycle.
REQ-009 Port: if_busy, input, 1, instruction fetch outstanding, no valid instruction this cycle.
REQ-010 Port: mem_busy, input, 1, data memory access in MEM not complete.
REQ-011 Ports: pc_fs, ifid_fs, idex_fs, exmem_fs, memwb_fs, output, 2 each, flush_and_stall control per pipeline register. Bit1 is flush, bit0 is stall.
REQ-012 Ports: stall_cnt, flush_cnt, output, CNT_WIDTH each, performance counters.
REQ-013 Port: discard_pending, output, 1, a wrong-path fetch is in flight.

Function
REQ-014 The *_fs outputs SHALL be combinational from the current inputs and the registered discard flag. 2'b11 SHALL never be driven.
REQ-015 Load-use hazard (LU) SHALL be defined as ex_MemRead & (ex_rd_addr!=0) & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
REQ-016 Priority SHALL be mem_busy > ex_branch_taken > LU > fetch bubble > run. Only the highest-priority active condition drives the outputs.
REQ-017 mem_busy=1: pc/ifid/idex/exmem = 01 (stall) and memwb = 10 (bubble into WB). The branch held in EX SHALL be acted on after mem_busy drops.
REQ-018 ex_branch_taken=1 (no mem_busy): pc = 00 (loads target), ifid = 10, idex = 10, exmem = 00, memwb = 00.
REQ-019 LU (no mem_busy, no branch): pc = 01, ifid = 01, idex = 10, exmem = 00, memwb = 00. This inserts exactly one bubble per load-use pair.
REQ-020 Fetch bubble, defined as if_busy=1 or (discard_pending=1 in the cycle if_busy deasserts), with no higher condition: pc = 01, ifid = 10, all others 00.
REQ-021 Run, with no condition active: all *_fs = 00.
REQ-022 discard_pending SHALL set on the clock edge where ex_branch_taken=1 & if_busy=1 & mem_busy=0.
REQ-023 discard_pending SHALL clear on the first clock edge where if_busy=0. In that cycle ifid SHALL be flushed (10) so that the wrong-path instruction is dropped, unless mem_busy=1, in which case the flag holds.
REQ-024 A second taken branch while discard_pending=1 SHALL keep the flag set. There is no double count and no second discard.
REQ-025 stall_cnt SHALL increment by 1 on every clock edge where pc_fs==01.
REQ-026 flush_cnt SHALL increment by 1 on every clock edge where ifid_fs==10 due to ex_branch_taken or discard.
REQ-027 Both counters SHALL wrap modulo 2^CNT_WIDTH without saturation.
REQ-028 The block SHALL be a single always_ff for state plus one combinational priority decode. No other internal storage.

Reset
REQ-029 reset SHALL asynchronously clear discard_pending, stall_cnt and flush_cnt to 0.
REQ-030 While reset=1, all *_fs outputs SHALL be 2'b00.
REQ-031 Reset asserted mid-discard SHALL drop the pending discard. After release, the first fetched instruction SHALL be accepted.
REQ-032 First post-reset edge: normal decode per REQ-016.

Verification
REQ-033 Load-use: ex_MemRead=1, ex_rd_addr=5, id_rs2_addr=5, id_uses_rs2=1 -> pc=01, ifid=01, idex=10 for exactly one cycle; stall_cnt +1. The same case with ex_rd_addr=0 -> all 00.
REQ-034 Branch: ex_branch_taken=1, if_busy=0 -> ifid=10, idex=10, pc=00; flush_cnt +1; discard_pending stays 0.
REQ-035 Branch during fetch: ex_branch_taken=1, if_busy=1 for 3 cycles then 0 -> discard_pending=1 after the first edge; ifid=10 in the if_busy-fall cycle; flag clears on that edge.
REQ-036 Memory wait: mem_busy=1 for 4 cycles with ex_branch_taken=1 and LU both true -> pc/ifid/idex/exmem=01 and memwb=10 for 4 cycles; stall_cnt +4; the branch flush occurs in cycle 5.
REQ-037 Wrap: preload stall_cnt to 2^CNT_WIDTH-1 via force, one stall cycle -> stall_cnt=0.
REQ-038 Reset: assert reset with discard_pending=1 and counters nonzero -> all cleared immediately; *_fs=00 while reset=1.
